microwave_control: RTL and testbench

MICROWAVE_CONTROL -- requirements
Module: microwave_control

---
 rtl/microwave_control.sv | 166 ++++++++++++++++
 tb/tb_microwave_control.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_control.sv
// Microwave oven controller: keypad digit entry, start/stop/clear buttons and
// door interlock driving a BCD countdown timer and the magnetron.
//
// Ports:
//   clock        - single clock, rising-edge active
//   clrn         - asynchronous active-low reset
//   keypad[9:0]  - digit keys 0-9, active-high, one bit per digit
//   startn       - start button, active-low
//   stopn        - stop button, active-low
//   clearn       - clear button, active-low
//   door_closed  - 1 = door closed
//   tick         - one-cycle 1 Hz strobe
//   timer_zero   - zero flag from the countdown timer
//   data[3:0]    - BCD digit to the timer's data input (registered)
//   loadn        - active-low digit-shift strobe to the timer (registered)
//   timer_clrn   - active-low clear to the timer (registered)
//   timer_enable - countdown enable: COOK and tick and door closed (combinational)
//   mag_on       - magnetron drive, high exactly while cooking (registered)
//   done         - cook-complete flag, high exactly while in DONE (registered)
module microwave_control (
  input  logic       clock,
  input  logic       clrn,
  input  logic [9:0] keypad,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  input  logic       tick,
  input  logic       timer_zero,
  output logic [3:0] data,
  output logic       loadn,
  output logic       timer_clrn,
  output logic       timer_enable,
  output logic       mag_on,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    COOK,
    PAUSE,
    DONE
  } state_t;

  state_t     state, state_nx;
  logic [1:0] count, count_nx;

  // Edge-detect history: released buttons are high, no key is low.
  logic key_q, start_q, stop_q, clear_q;
  logic key_press, start_ev, stop_ev, clear_ev;

  logic [3:0] digit;
  logic       accept;
  logic       start_ok;
  logic       done_exit;

  logic [3:0] data_nx;
  logic       loadn_nx, timer_clrn_nx, mag_on_nx, done_nx;

  assign key_press = (|keypad) & ~key_q;
  assign start_ev  = start_q & ~startn;
  assign stop_ev   = stop_q  & ~stopn;
  assign clear_ev  = clear_q & ~clearn;

  assign start_ok  = start_ev & door_closed & ~timer_zero & (count != 2'd0);

  // Scan from the highest key down so the lowest asserted key is written last.
  always_comb begin
    digit = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (keypad[9 - i]) digit = 4'(9 - i);
    end
  end

  // State register and all registered outputs
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      count      <= '0;
      key_q      <= 1'b0;
      start_q    <= 1'b1;
      stop_q     <= 1'b1;
      clear_q    <= 1'b1;
      data       <= '0;
      loadn      <= 1'b1;
      timer_clrn <= 1'b0;
      mag_on     <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      key_q      <= |keypad;
      start_q    <= startn;
      stop_q     <= stopn;
      clear_q    <= clearn;
      data       <= data_nx;
      loadn      <= loadn_nx;
      timer_clrn <= timer_clrn_nx;
      mag_on     <= mag_on_nx;
      done       <= done_nx;
    end
  end

  // Next-state logic; clear overrides every other event
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    done_exit = 1'b0;
    if (clear_ev) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (key_press && count != 2'd3) begin
            accept   = 1'b1;
            state_nx = ENTRY;
          end
        end
        ENTRY: begin
          // A valid start takes the cycle; the coincident key is dropped.
          if (start_ok) begin
            state_nx = COOK;
          end else if (key_press && count != 2'd3) begin
            accept = 1'b1;
          end
        end
        COOK: begin
          if (timer_zero) begin
            state_nx = DONE;
          end else if (stop_ev || !door_closed) begin
            state_nx = PAUSE;
          end
        end
        PAUSE: begin
          if (start_ok) state_nx = COOK;
        end
        DONE: begin
          if (key_press || !door_closed) begin
            state_nx  = IDLE;
            done_exit = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output logic: next values for the registered outputs plus timer_enable
  always_comb begin
    data_nx       = accept ? digit : data;
    loadn_nx      = ~accept;
    timer_clrn_nx = ~(clear_ev | done_exit);
    mag_on_nx     = (state_nx == COOK);
    done_nx       = (state_nx == DONE);
    if (clear_ev || done_exit) begin
      count_nx = '0;
    end else if (accept) begin
      count_nx = count + 2'd1;
    end else begin
      count_nx = count;
    end
    timer_enable = (state == COOK) & tick & door_closed;
  end

endmodule

// File: tb/tb_microwave_control.sv
module tb_microwave_control;

  logic       clock;
  logic       clrn;
  logic [9:0] keypad;
  logic       startn, stopn, clearn;
  logic       door_closed, tick, timer_zero;
  logic [3:0] data;
  logic       loadn, timer_clrn, timer_enable, mag_on, done;

  int n_checks = 0;
  int n_fail   = 0;

  microwave_control dut (
    .clock        (clock),
    .clrn         (clrn),
    .keypad       (keypad),
    .startn       (startn),
    .stopn        (stopn),
    .clearn       (clearn),
    .door_closed  (door_closed),
    .tick         (tick),
    .timer_zero   (timer_zero),
    .data         (data),
    .loadn        (loadn),
    .timer_clrn   (timer_clrn),
    .timer_enable (timer_enable),
    .mag_on       (mag_on),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clearn = 1'b0;
    cyc();
    chk("clear_tclrn_low", 32'(timer_clrn), 32'd0);
    chk("clear_count", 32'(dut.count), 32'd0);
    clearn = 1'b1;
    cyc();
    chk("clear_tclrn_high", 32'(timer_clrn), 32'd1);
  endtask

  logic [9:0] keys [4];

  initial begin
    keys[0] = 10'h002;
    keys[1] = 10'h004;
    keys[2] = 10'h008;
    keys[3] = 10'h010;

    clrn = 1'b0; keypad = '0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; tick = 1'b0; timer_zero = 1'b0;

    // Reset values
    #12;
    chk("rst_loadn", 32'(loadn), 32'd1);
    chk("rst_tclrn", 32'(timer_clrn), 32'd0);
    chk("rst_mag", 32'(mag_on), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_count", 32'(dut.count), 32'd0);
    cyc();
    clrn = 1'b1;
    cyc();
    chk("rel_tclrn", 32'(timer_clrn), 32'd1);

    // Key 3
    keypad = 10'h008;
    cyc();
    chk("k3_loadn", 32'(loadn), 32'd0);
    chk("k3_data", 32'(data), 32'd3);
    chk("k3_count", 32'(dut.count), 32'd1);
    cyc();
    chk("k3_loadn_one", 32'(loadn), 32'd1);
    keypad = '0;
    cyc();
    chk("k3_data_hold", 32'(data), 32'd3);

    // Keys 1..4, the fourth is ignored
    do_clear();
    for (int i = 0; i < 4; i++) begin
      keypad = keys[i];
      cyc();
      chk("seq_loadn", 32'(loadn), (i < 3) ? 32'd0 : 32'd1);
      chk("seq_data", 32'(data), (i < 3) ? 32'(i + 1) : 32'd3);
      keypad = '0;
      cyc();
      chk("seq_loadn_rel", 32'(loadn), 32'd1);
    end
    chk("seq_count", 32'(dut.count), 32'd3);

    // Keys 5 and 7 together
    do_clear();
    keypad = 10'h0A0;
    cyc();
    chk("k57_loadn", 32'(loadn), 32'd0);
    chk("k57_data", 32'(data), 32'd5);
    keypad = '0;
    cyc();

    // Start cooking
    startn = 1'b0;
    cyc();
    chk("cook_mag", 32'(mag_on), 32'd1);
    chk("cook_en_notick", 32'(timer_enable), 32'd0);
    startn = 1'b1;
    tick = 1'b1;
    #1;
    chk("cook_en_tick", 32'(timer_enable), 32'd1);
    tick = 1'b0;
    cyc();
    // Keys ignored in COOK
    keypad = 10'h001;
    cyc();
    chk("cook_key_loadn", 32'(loadn), 32'd1);
    chk("cook_key_data", 32'(data), 32'd5);
    keypad = '0;
    cyc();
    // Door opens
    door_closed = 1'b0;
    tick = 1'b1;
    #1;
    chk("door_en", 32'(timer_enable), 32'd0);
    tick = 1'b0;
    cyc();
    chk("pause_mag", 32'(mag_on), 32'd0);
    // Start with door open is ignored
    startn = 1'b0;
    cyc();
    chk("pause_open_start", 32'(mag_on), 32'd0);
    startn = 1'b1;
    cyc();
    door_closed = 1'b1;
    cyc();
    startn = 1'b0;
    cyc();
    chk("resume_mag", 32'(mag_on), 32'd1);
    startn = 1'b1;
    cyc();

    // timer_zero and stop together -> DONE
    timer_zero = 1'b1;
    stopn = 1'b0;
    cyc();
    chk("done_flag", 32'(done), 32'd1);
    chk("done_mag", 32'(mag_on), 32'd0);
    timer_zero = 1'b0;
    stopn = 1'b1;
    cyc();
    chk("done_hold", 32'(done), 32'd1);
    keypad = 10'h004;
    cyc();
    chk("dexit_done", 32'(done), 32'd0);
    chk("dexit_tclrn", 32'(timer_clrn), 32'd0);
    chk("dexit_loadn", 32'(loadn), 32'd1);
    chk("dexit_data", 32'(data), 32'd5);
    chk("dexit_count", 32'(dut.count), 32'd0);
    keypad = '0;
    cyc();
    chk("dexit_tclrn_one", 32'(timer_clrn), 32'd1);
    chk("dexit_loadn_rel", 32'(loadn), 32'd1);

    // Back into COOK, then clear together with start
    keypad = 10'h002;
    cyc();
    chk("k1_loadn", 32'(loadn), 32'd0);
    chk("k1_data", 32'(data), 32'd1);
    keypad = '0;
    cyc();
    startn = 1'b0;
    cyc();
    chk("cook2_mag", 32'(mag_on), 32'd1);
    startn = 1'b1;
    cyc();
    startn = 1'b0;
    clearn = 1'b0;
    cyc();
    chk("clr_mag", 32'(mag_on), 32'd0);
    chk("clr_tclrn", 32'(timer_clrn), 32'd0);
    chk("clr_count", 32'(dut.count), 32'd0);
    startn = 1'b1;
    clearn = 1'b1;
    cyc();
    chk("clr_tclrn_one", 32'(timer_clrn), 32'd1);
    chk("clr_mag_stay", 32'(mag_on), 32'd0);

    // Asynchronous reset mid-COOK
    keypad = 10'h010;
    cyc();
    keypad = '0;
    cyc();
    startn = 1'b0;
    cyc();
    startn = 1'b1;
    chk("cook3_mag", 32'(mag_on), 32'd1);
    tick = 1'b1;
    #1;
    chk("cook3_en", 32'(timer_enable), 32'd1);
    clrn = 1'b0;
    #1;
    chk("arst_mag", 32'(mag_on), 32'd0);
    chk("arst_en", 32'(timer_enable), 32'd0);
    chk("arst_tclrn", 32'(timer_clrn), 32'd0);
    tick = 1'b0;
    cyc();
    clrn = 1'b1;
    cyc();
    chk("arst_rel_tclrn", 32'(timer_clrn), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
